// File: rtl/seg_value_encoder.sv
// seg_value_encoder: converts a 14-bit binary value to four 7-segment characters
// using a serial double-dabble (one step per cycle, 15-cycle latency).
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_value_encoder #(
    parameter logic [3:0] DP_MASK = 4'b0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [13:0]     in_value,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3:0][7:0] chars,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [13:0]     shift_q;
    logic [15:0]     bcd_q;
    logic [15:0]     bcd_adj;
    logic [3:0]      count_q;
    logic            overflow_q;
    logic            accept;
    logic [3:0]      blank;
    logic [3:0][7:0] chars_next;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    function automatic logic [7:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; illegal encodings fall back to IDLE
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? CONVERT : IDLE;
            CONVERT: state_next = (count_q == 4'd0) ? LOAD : CONVERT;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction of every BCD nibble >= 5 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end else begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
            end
        end
    end

    // Leading-zero blanking flags; the ones digit is never blanked
    always_comb begin
        blank = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank[3] = (bcd_q[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
`endif
    end

    // Character patterns presented at LOAD, with decimal points merged in
    always_comb begin
        chars_next = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (overflow_q) begin
                chars_next[i] = 8'h40;
            end else if (blank[i]) begin
                chars_next[i] = 8'h00;
            end else begin
                chars_next[i] = seg7(bcd_q[i*4 +: 4]);
            end
            chars_next[i][7] = chars_next[i][7] | DP_MASK[i];
        end
    end

    // Datapath: latch on accept, shift in CONVERT, publish in LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            chars      <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state == LOAD);
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q    <= in_value;
                        bcd_q      <= '0;
                        count_q    <= 4'd13;
                        overflow_q <= (in_value > 14'd9999);
                    end
                end
                CONVERT: begin
                    bcd_q   <= {bcd_adj[14:0], shift_q[13]};
                    shift_q <= {shift_q[12:0], 1'b0};
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end
                end
                LOAD: begin
                    chars <= chars_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_value_encoder.sv
// Directed self-checking bench for seg_value_encoder (default DP_MASK and DP_MASK=4'b0100).
module tb_seg_value_encoder;

    logic            clk;
    logic            rst_n;
    logic [13:0]     in_value;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] chars;
    logic            done;

    logic [13:0]     dp_value;
    logic            dp_valid;
    logic            dp_ready;
    logic [3:0][7:0] dp_chars;
    logic            dp_done;

    int errors;
    int checks;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] EXP_7  = 32'h0000_0007;
    localparam logic [31:0] EXP_0  = 32'h0000_003F;
    localparam logic [31:0] EXP_9  = 32'h0000_006F;
    localparam logic [31:0] EXP_42 = 32'h0000_665B;
`else
    localparam logic [31:0] EXP_7  = 32'h3F3F_3F07;
    localparam logic [31:0] EXP_0  = 32'h3F3F_3F3F;
    localparam logic [31:0] EXP_9  = 32'h3F3F_3F6F;
    localparam logic [31:0] EXP_42 = 32'h3F3F_665B;
`endif

    seg_value_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .chars    (chars),
        .done     (done)
    );

    seg_value_encoder #(.DP_MASK(4'b0100)) dut_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_value (dp_value),
        .in_valid (dp_valid),
        .in_ready (dp_ready),
        .chars    (dp_chars),
        .done     (dp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n posedges, ending 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a value so it is taken on the next posedge (edge N); returns at N+1tu
    task automatic start(input logic [13:0] v);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (chars !== 32'h0) begin errors++; $display("FAIL reset_chars got=%h exp=%h", chars, 32'h0); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        // release mid-cycle with a value already offered: first posedge must accept it
        @(negedge clk);
        rst_n    = 1'b1;
        in_value = 14'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL first_accept_ready got=%b exp=0", in_ready); end
        tick(15);
        checks++;
        if (chars !== EXP_9 || done !== 1'b1) begin
            errors++; $display("FAIL first_accept_result got=%h/%b exp=%h/1", chars, done, EXP_9);
        end
    endtask

    task automatic test_basic;
        int bad;
        start(14'd1234);
        bad = 0;
        // edges N .. N+14: busy, no done, old chars held
        for (int k = 0; k < 15; k++) begin
            if (in_ready !== 1'b0 || done !== 1'b0 || chars !== EXP_9) bad++;
            if (k < 14) tick(1);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_busy bad_cycles=%0d exp=0", bad); end
        tick(1);
        checks++;
        if (chars !== 32'h065B_4F66) begin errors++; $display("FAIL basic_chars got=%h exp=%h", chars, 32'h065B4F66); end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_done got done=%b ready=%b exp 1/1", done, in_ready);
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || chars !== 32'h065B_4F66) begin
            errors++; $display("FAIL basic_after got done=%b chars=%h exp 0/%h", done, chars, 32'h065B4F66);
        end
    endtask

    task automatic test_overflow;
        start(14'd10000);
        tick(15);
        checks++;
        if (chars !== 32'h4040_4040 || done !== 1'b1) begin
            errors++; $display("FAIL ovf_10000 got=%h/%b exp=40404040/1", chars, done);
        end
        start(14'd16383);
        tick(14);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL ovf_latency got done=%b exp=0 at N+14", done); end
        tick(1);
        checks++;
        if (chars !== 32'h4040_4040 || done !== 1'b1) begin
            errors++; $display("FAIL ovf_16383 got=%h/%b exp=40404040/1", chars, done);
        end
    endtask

    task automatic test_leading_zero;
        start(14'd7);
        tick(15);
        checks++;
        if (chars !== EXP_7) begin errors++; $display("FAIL digits_7 got=%h exp=%h", chars, EXP_7); end
        start(14'd0);
        tick(15);
        checks++;
        if (chars !== EXP_0) begin errors++; $display("FAIL digits_0 got=%h exp=%h", chars, EXP_0); end
    endtask

    task automatic test_dp_mask;
        dp_value = 14'd9999;
        dp_valid = 1'b1;
        tick(1);
        dp_valid = 1'b0;
        tick(15);
        checks++;
        if (dp_chars !== 32'h6FEF_6F6F || dp_done !== 1'b1) begin
            errors++; $display("FAIL dp_9999 got=%h/%b exp=6fef6f6f/1", dp_chars, dp_done);
        end
        dp_value = 14'd12000;
        dp_valid = 1'b1;
        tick(1);
        dp_valid = 1'b0;
        tick(15);
        checks++;
        if (dp_chars !== 32'h40C0_4040) begin
            errors++; $display("FAIL dp_ovf got=%h exp=40c04040", dp_chars);
        end
    endtask

    task automatic test_back_to_back;
        start(14'd5555);           // edge N
        tick(4);                   // after N+4
        in_value = 14'd1111;
        in_valid = 1'b1;
        tick(1);                   // edge N+5 while busy
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", in_ready); end
        tick(10);                  // after N+15
        checks++;
        if (chars !== 32'h6D6D_6D6D || done !== 1'b1) begin
            errors++; $display("FAIL b2b_5555 got=%h/%b exp=6d6d6d6d/1", chars, done);
        end
        start(14'd1111);           // edge N+16
        tick(4);
        checks++;
        if (chars !== 32'h6D6D_6D6D || done !== 1'b0) begin
            errors++; $display("FAIL b2b_hold got=%h/%b exp=6d6d6d6d/0", chars, done);
        end
        tick(11);                  // after N+31
        checks++;
        if (chars !== 32'h0606_0606 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_1111 got=%h/%b exp=06060606/1", chars, done);
        end
    endtask

    task automatic test_reset_abort;
        int bad;
        start(14'd4321);           // edge N
        tick(6);                   // after N+6
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (chars !== 32'h0 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_state got chars=%h done=%b ready=%b exp 0/0/1", chars, done, in_ready);
        end
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (done !== 1'b0 || chars !== 32'h0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_load bad_cycles=%0d exp=0", bad); end
        start(14'd42);
        tick(15);
        checks++;
        if (chars !== EXP_42 || done !== 1'b1) begin
            errors++; $display("FAIL abort_42 got=%h/%b exp=%h/1", chars, done, EXP_42);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_value = '0;
        in_valid = 1'b0;
        dp_value = '0;
        dp_valid = 1'b0;
        test_reset;
        tick(1);
        test_basic;
        test_overflow;
        tick(1);
        test_leading_zero;
        tick(1);
        test_dp_mask;
        tick(1);
        test_back_to_back;
        tick(1);
        test_reset_abort;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
